bd_scan_7seg: RTL and testbench

BD_SCAN_7SEG -- requirements
Module: bd_scan_7seg

---
 rtl/bd_scan_7seg.sv | 130 +++++++++++++
 tb/tb_bd_scan_7seg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bd_scan_7seg.sv
// bd_scan_7seg: two-digit multiplexed 7-segment scanner.
// Cycles BLANK0 -> SHOW0 -> BLANK1 -> SHOW1, with all digits off in the BLANK
// phases so that digit switching does not ghost. The bcd input is captured
// once per frame, at the SHOW1 -> BLANK0 edge. The segment and anode drives
// are active-low. frame pulses for one cycle at the start of each new frame.
// Optional macro BD_SCAN_LZ_BLANK_EN: blank a leading zero in the tens digit.
module bd_scan_7seg #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int unsigned MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [1:0] AN_OFF  = 2'b11;

    typedef enum logic [1:0] {
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lat_q, lat_d;
    logic [6:0]    seg_d;
    logic [1:0]    an_d;
    logic          frame_d;
    logic          phase_end;

    // Digit decode, active-low g..a; 10-15 shown as a dash.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b0111111;
        endcase
    endfunction

    // Next state, phase counter, frame latch, and the output values for the
    // state being entered, so the registered outputs line up with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        lat_d   = lat_q;
        frame_d = 1'b0;
        seg_d   = SEG_OFF;
        an_d    = AN_OFF;

        if (state_q == SHOW0 || state_q == SHOW1)
            phase_end = (cnt_q == SHOW_LAST);
        else
            phase_end = (cnt_q == BLANK_LAST);

        if (phase_end) begin
            cnt_d = '0;
            case (state_q)
                BLANK0:  state_d = SHOW0;
                SHOW0:   state_d = BLANK1;
                BLANK1:  state_d = SHOW1;
                default: begin
                    state_d = BLANK0;
                    lat_d   = bcd;
                    frame_d = 1'b1;
                end
            endcase
        end

        case (state_d)
            SHOW0: begin
                an_d  = 2'b10;
                seg_d = dec7(lat_d[3:0]);
            end
            SHOW1: begin
`ifdef BD_SCAN_LZ_BLANK_EN
                if (lat_d[7:4] != 4'd0) begin
                    an_d  = 2'b01;
                    seg_d = dec7(lat_d[7:4]);
                end
`else
                an_d  = 2'b01;
                seg_d = dec7(lat_d[7:4]);
`endif
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
            end
        endcase
    end

    // State, counter, latch and registered output drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK0;
            cnt_q   <= '0;
            lat_q   <= '0;
            seg     <= SEG_OFF;
            an      <= AN_OFF;
            frame   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            seg     <= seg_d;
            an      <= an_d;
            frame   <= frame_d;
        end
    end

endmodule

// File: tb/tb_bd_scan_7seg.sv
// Testbench for bd_scan_7seg with SCAN_DIV=4, BLANK_CYC=2 (12-cycle frame).
// A frame-position reference model produces the expected outputs for each
// cycle, pushes them to a scoreboard queue, and they are popped and compared
// after the clock edge. Honours BD_SCAN_LZ_BLANK_EN in the model.
module tb_bd_scan_7seg;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned PERIOD    = 2 * (SCAN_DIV + BLANK_CYC);

    logic       clk;
    logic       rst_n;
    logic [7:0] bcd;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    bd_scan_7seg #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an),
        .frame (frame)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [9:0]  sb_q[$];   // {an, seg, frame}
    logic [6:0]  seg_tab[16];

    // Reference model: position in frame, latched value, post-reset flag.
    int unsigned m_pos;
    logic [7:0]  m_lat;
    logic        m_fresh;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_out(input int unsigned p, input logic [7:0] lat,
                                            input logic fresh);
        logic [1:0] a;
        logic [6:0] s;
        logic       f;
        a = 2'b11;
        s = 7'b1111111;
        f = (p == 0) && !fresh;
        if (p >= BLANK_CYC && p < BLANK_CYC + SCAN_DIV) begin
            a = 2'b10;
            s = seg_tab[lat[3:0]];
        end else if (p >= 2 * BLANK_CYC + SCAN_DIV) begin
`ifdef BD_SCAN_LZ_BLANK_EN
            if (lat[7:4] != 4'd0) begin
                a = 2'b01;
                s = seg_tab[lat[7:4]];
            end
`else
            a = 2'b01;
            s = seg_tab[lat[7:4]];
`endif
        end
        return {a, s, f};
    endfunction

    // One clock: drive inputs, advance the model, push expectation, then
    // sample the DUT shortly after the edge and compare against the queue.
    task automatic cyc(input logic r, input logic [7:0] b);
        logic [9:0] e;
        logic [9:0] o;
        @(negedge clk);
        rst_n = r;
        bcd   = b;
        if (!r) begin
            m_pos   = 0;
            m_lat   = 8'h00;
            m_fresh = 1'b1;
        end else if (m_pos == PERIOD - 1) begin
            m_pos   = 0;
            m_lat   = b;
            m_fresh = 1'b0;
        end else begin
            m_pos = m_pos + 1;
        end
        sb_q.push_back(model_out(m_pos, m_lat, m_fresh));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        o = {an, seg, frame};
        check("an",    {8'd0, o[9:8]}, {8'd0, e[9:8]});
        check("seg",   {3'd0, o[7:1]}, {3'd0, e[7:1]});
        check("frame", {9'd0, o[0]},   {9'd0, e[0]});
    endtask

    task automatic run(input int unsigned n, input logic r, input logic [7:0] b);
        for (int unsigned i = 0; i < n; i++) cyc(r, b);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        n_cmp   = 0;
        n_bad   = 0;
        m_pos   = 0;
        m_lat   = 8'h00;
        m_fresh = 1'b1;
        clk     = 1'b0;
        rst_n   = 1'b0;
        bcd     = 8'h00;

        // Reset held three cycles; first frame must show 00.
        run(3, 1'b0, 8'h99);
        run(4, 1'b1, 8'h00);
        // New value applied mid-frame: must not appear until next frame.
        run(20, 1'b1, 8'h15);
        // Invalid units nibble, tens zero.
        run(12, 1'b1, 8'h0C);
        // Leading zero case.
        run(12, 1'b1, 8'h07);
        // Latch 42, then reset in the middle of SHOW1.
        run(12, 1'b1, 8'h42);
        run(9, 1'b1, 8'h42);
        run(1, 1'b0, 8'h42);
        run(14, 1'b1, 8'h42);
        // Five frames of random values, including invalid nibbles.
        for (int unsigned k = 0; k < 10; k++)
            run(6, 1'b1, 8'($urandom_range(0, 255)));
        // Sweep every digit value through both positions.
        for (int unsigned d = 0; d < 16; d++)
            run(PERIOD, 1'b1, {4'(15 - d), 4'(d)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
